// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller. Detects load-use hazards, taken branches/jumps
// resolved in EX and multi-cycle memory waits, and produces the hold (WREN)
// and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB
// pipeline registers. The controls are Mealy outputs of the current state and
// inputs; the pipeline registers act on them at the following posedge.
//
// Optional build macro: HAZARD_STATS_EN
//   When defined, adds saturating statistics counters stall_cnt, flush_cnt
//   and memwait_cnt (CNT_W bits each).
//
// Parameters:
//   MEM_TIMEOUT  cycles allowed in MEMWAIT before the wait is abandoned
//   CNT_W        width of the wait counter and statistics counters
//
// Ports:
//   clock, reset        clock, asynchronous active-high reset
//   ID_RS, ID_RT        source registers of the instruction in ID
//   ID_UsesRT           ID instruction reads rt as a source
//   EX_MEM_RDEN, EX_RT  load in EX and its destination register
//   EX_PCSrc            nonzero = taken branch/jump resolved in EX
//   MEM_req, MEM_ready  memory access outstanding / completing this cycle
//   PC_WREN .. MEM_WB_flush  pipeline hold/flush controls
//   mem_timeout         sticky memory-wait timeout flag
//   state               FSM state (RUN=0, LOADUSE=1, MEMWAIT=2)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       ID_RS,
    input  logic [4:0]       ID_RT,
    input  logic             ID_UsesRT,
    input  logic             EX_MEM_RDEN,
    input  logic [4:0]       EX_RT,
    input  logic [1:0]       EX_PCSrc,
    input  logic             MEM_req,
    input  logic             MEM_ready,
    output logic             PC_WREN,
    output logic             IF_ID_WREN,
    output logic             IF_ID_flush,
    output logic             ID_EX_WREN,
    output logic             ID_EX_flush,
    output logic             EX_MEM_WREN,
    output logic             MEM_WB_flush,
    output logic             mem_timeout,
    output logic [1:0]       state
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
`endif
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_LOADUSE = 2'd1;
    localparam logic [1:0] ST_MEMWAIT = 2'd2;

    // Control vector bit order:
    // {PC_WREN, IF_ID_WREN, IF_ID_flush, ID_EX_WREN, ID_EX_flush, EX_MEM_WREN, MEM_WB_flush}
    localparam logic [6:0] CTRL_DEFAULT = 7'b1101010;
    localparam logic [6:0] CTRL_HOLD    = 7'b0000001;  // freeze front end, bubble into MEM/WB
    localparam logic [6:0] CTRL_FLUSH   = 7'b1111110;  // squash IF/ID and ID/EX, PC takes target
    localparam logic [6:0] CTRL_STALL   = 7'b0001110;  // hold PC and IF/ID, bubble into ID/EX

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             mem_timeout_q;
    logic             mem_timeout_d;
    logic [6:0]       ctrl_s;
    logic             lu_s;
    logic             mw_s;
    logic             br_s;

    // Hazard detection terms; register 0 never creates a dependency.
    assign lu_s = EX_MEM_RDEN & (EX_RT != 5'd0) &
                  ((EX_RT == ID_RS) | (ID_UsesRT & (EX_RT == ID_RT)));
    assign mw_s = MEM_req & ~MEM_ready;
    assign br_s = (EX_PCSrc != 2'b00);

    // Next-state, wait counter and control decode; priority is mw > branch > lu.
    always_comb begin
        ctrl_s        = CTRL_DEFAULT;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_RUN: begin
                if (mw_s) begin
                    ctrl_s     = CTRL_HOLD;
                    state_d    = ST_MEMWAIT;
                    wait_cnt_d = CNT_ZERO;
                end else if (br_s) begin
                    // A coincident load-use is moot: the dependent instruction is squashed.
                    ctrl_s  = CTRL_FLUSH;
                    state_d = ST_RUN;
                end else if (lu_s) begin
                    ctrl_s  = CTRL_STALL;
                    state_d = ST_LOADUSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOADUSE: begin
                // EX now holds the bubble, so load-use is masked for this cycle.
                if (mw_s) begin
                    ctrl_s     = CTRL_HOLD;
                    state_d    = ST_MEMWAIT;
                    wait_cnt_d = CNT_ZERO;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEMWAIT: begin
                if (mw_s) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        // Abandon the wait: release the pipeline and flag it.
                        mem_timeout_d = 1'b1;
                        state_d       = ST_RUN;
                        wait_cnt_d    = CNT_ZERO;
                    end else begin
                        ctrl_s     = CTRL_HOLD;
                        state_d    = ST_MEMWAIT;
                        wait_cnt_d = wait_cnt_q + CNT_ONE;
                    end
                end else begin
                    // Release cycle: hazards held during the wait are handled now.
                    wait_cnt_d = CNT_ZERO;
                    if (br_s) begin
                        ctrl_s  = CTRL_FLUSH;
                        state_d = ST_RUN;
                    end else if (lu_s) begin
                        ctrl_s  = CTRL_STALL;
                        state_d = ST_LOADUSE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                // Unreachable encoding: recover to RUN with default controls.
                state_d    = ST_RUN;
                wait_cnt_d = CNT_ZERO;
            end
        endcase
    end

    // FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= CNT_ZERO;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // All enables and flushes are forced low while reset is asserted.
    assign {PC_WREN, IF_ID_WREN, IF_ID_flush, ID_EX_WREN,
            ID_EX_flush, EX_MEM_WREN, MEM_WB_flush} = reset ? 7'b0000000 : ctrl_s;
    assign mem_timeout = mem_timeout_q;
    assign state       = state_q;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] memwait_cnt_q;
    logic             stall_evt_s;
    logic             flush_evt_s;
    logic             hold_evt_s;

    // Events are recovered from the decoded control vector.
    assign stall_evt_s = (ctrl_s == CTRL_STALL);
    assign flush_evt_s = (ctrl_s == CTRL_FLUSH);
    assign hold_evt_s  = (state_q == ST_MEMWAIT) && (ctrl_s == CTRL_HOLD);

    // Saturating statistics counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q   <= CNT_ZERO;
            flush_cnt_q   <= CNT_ZERO;
            memwait_cnt_q <= CNT_ZERO;
        end else begin
            if (stall_evt_s && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (flush_evt_s && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end else begin
                flush_cnt_q <= flush_cnt_q;
            end
            if (hold_evt_s && !(&memwait_cnt_q)) begin
                memwait_cnt_q <= memwait_cnt_q + CNT_ONE;
            end else begin
                memwait_cnt_q <= memwait_cnt_q;
            end
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign memwait_cnt = memwait_cnt_q;
`endif

endmodule
